// File: rtl/srl_serial_if.sv
`default_nettype none
// ============================================================================
// Module   : srl_serial_if
// Brief    : Start/operand/result bundle between the controller and srl_serial.
// Revision : 1.0 - initial release
// ============================================================================
interface srl_serial_if #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
);
   logic               start_i;
   logic [WIDTH-1:0]   entrada_i;
   logic [SHAMT_W-1:0] shamt_i;
   logic               arith_i;
   logic [WIDTH-1:0]   salida_o;
   logic               busy_o;
   logic               done_o;

   modport master (
      output start_i, entrada_i, shamt_i, arith_i,
      input  salida_o, busy_o, done_o
   );

   modport slave (
      input  start_i, entrada_i, shamt_i, arith_i,
      output salida_o, busy_o, done_o
   );
endinterface
`default_nettype wire

// File: rtl/srl_serial.sv
`default_nettype none
// ============================================================================
// Module   : srl_serial
// Brief    : Multi-cycle SRL/SRA shifter, one bit per clock behind start/busy/done.
//            Define SRL_SERIAL_STEP4_EN to shift by 4 while at least 4 remain.
// Revision : 1.0 - initial release
// ============================================================================
module srl_serial #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  wire logic clk_i,
   input  wire logic rst_i,
   srl_serial_if.slave bus
);
   localparam logic [1:0] c_idle  = 2'd0;
   localparam logic [1:0] c_shift = 2'd1;
   localparam logic [1:0] c_done  = 2'd2;

   localparam logic [SHAMT_W:0] c_last = (SHAMT_W + 1)'(WIDTH - 1);

   logic [1:0]         r_state;
   logic [WIDTH-1:0]   r_reg;
   logic [WIDTH-1:0]   r_salida;
   logic [SHAMT_W-1:0] r_count;
   logic               r_fill;

   logic [SHAMT_W-1:0] w_shamt_sat;
   logic               w_fill_in;
   logic [WIDTH-1:0]   w_shift;
   logic [SHAMT_W-1:0] w_count_nxt;
   logic               w_last;

   // Oversized amounts clamp to the widest meaningful shift.
   assign w_shamt_sat = ({1'b0, bus.shamt_i} > c_last) ? c_last[SHAMT_W-1:0] : bus.shamt_i;
   assign w_fill_in   = bus.arith_i & bus.entrada_i[WIDTH-1];

   always_comb begin
      w_shift     = {r_fill, r_reg[WIDTH-1:1]};
      w_count_nxt = r_count - SHAMT_W'(1);
      w_last      = (r_count == SHAMT_W'(1));
`ifdef SRL_SERIAL_STEP4_EN
      if (r_count >= SHAMT_W'(4)) begin
         w_shift     = {{4{r_fill}}, r_reg[WIDTH-1:4]};
         w_count_nxt = r_count - SHAMT_W'(4);
         w_last      = (r_count == SHAMT_W'(4));
      end
`endif
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state  <= c_idle;
         r_reg    <= '0;
         r_salida <= '0;
         r_count  <= '0;
         r_fill   <= 1'b0;
      end else begin
         case (r_state)
            c_idle: begin
               if (bus.start_i) begin
                  r_reg   <= bus.entrada_i;
                  r_count <= w_shamt_sat;
                  r_fill  <= w_fill_in;
                  // A zero shift completes straight away with the operand itself.
                  if (w_shamt_sat == '0) begin
                     r_salida <= bus.entrada_i;
                     r_state  <= c_done;
                  end else begin
                     r_state  <= c_shift;
                  end
               end
            end
            c_shift: begin
               r_reg   <= w_shift;
               r_count <= w_count_nxt;
               if (w_last) begin
                  r_salida <= w_shift;
                  r_state  <= c_done;
               end
            end
            c_done:  r_state <= c_idle;
            default: r_state <= c_idle;
         endcase
      end
   end

   assign bus.salida_o = r_salida;
   assign bus.busy_o   = (r_state == c_shift);
   assign bus.done_o   = (r_state == c_done);
endmodule
`default_nettype wire
